fpga_ip_demo_cpu_ocimem_arbiter: RTL

Arbitrates the Nios II on-chip-instrumentation (OCI) debug RAM between two requesters: the CPU debug-slave Avalon port and the JTAG debug module's sysclk-side command strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a` with `jdo`). It latches one pending JTAG command, auto-increments the JTAG word address, round-robins contention, and returns JTAG read data on `MonDReg`. It sits between the JTAG debug module wrapper and the single-port debug RAM.

---
 rtl/fpga_ip_demo_cpu_ocimem_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fpga_ip_demo_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: CPU Avalon slave vs JTAG ocimem strobes.
// Ports: av_* CPU side, take_*/jdo JTAG side, ram_* RAM side, MonDReg/jtag_* status.
module fpga_ip_demo_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  output logic              av_waitrequest,
  output logic [31:0]       av_readdata,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_done,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU_RDATA,
    S_JTAG_RDATA
  } state_t;

  state_t state_q, state_d;

  logic              pending_q, pending_d;
  logic              op_wr_q, op_wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic [31:0]       mondreg_q, mondreg_d;
  logic              last_jtag_q, last_jtag_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic busy;
  logic in_idle;
  logic cpu_req;
  logic grant_jtag;
  logic grant_cpu;
  logic acc_a;
  logic acc_b;
  logic acc_na;
  logic multi;

  // jdo bits outside the address and data fields are not used here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign busy    = pending_q | (state_q == S_JTAG_RDATA);
  assign in_idle = (state_q == S_IDLE) & ~reset;
  assign cpu_req = av_read | av_write;

  // Tie goes to whichever side was not served last.
  assign grant_jtag = in_idle & pending_q
                    & (~cpu_req | ~last_jtag_q);
  assign grant_cpu  = in_idle & cpu_req & ~grant_jtag;

  assign acc_a  = ~busy & take_action_ocimem_a;
  assign acc_b  = ~busy & ~take_action_ocimem_a
                & take_action_ocimem_b;
  assign acc_na = ~busy & ~take_action_ocimem_a
                & ~take_action_ocimem_b
                & take_no_action_ocimem_a;

  assign multi = (take_action_ocimem_a & take_action_ocimem_b)
               | (take_action_ocimem_a & take_no_action_ocimem_a)
               | (take_action_ocimem_b & take_no_action_ocimem_a);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_jtag && !op_wr_q) begin
          state_d = S_JTAG_RDATA;
        end else if (grant_cpu && !av_write) begin
          state_d = S_CPU_RDATA;
        end
      end
      S_CPU_RDATA:  state_d = S_IDLE;
      S_JTAG_RDATA: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ram_addr       = jaddr_q;
    ram_wdata      = wdata_q;
    ram_wr         = 1'b0;
    ram_rd         = 1'b0;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    if (grant_jtag) begin
      ram_wr = op_wr_q;
      ram_rd = ~op_wr_q;
    end
    if (grant_cpu) begin
      ram_addr       = av_address;
      ram_wdata      = av_writedata;
      ram_wr         = av_write;
      ram_rd         = ~av_write;
      av_waitrequest = ~av_write;
    end
    if (state_q == S_CPU_RDATA && !reset) begin
      av_readdata    = ram_rdata;
      av_waitrequest = 1'b0;
    end
  end

  // JTAG command, address and status datapath
  always_comb begin
    pending_d   = pending_q;
    op_wr_d     = op_wr_q;
    wdata_d     = wdata_q;
    jaddr_d     = jaddr_q;
    mondreg_d   = mondreg_q;
    last_jtag_d = last_jtag_q;
    done_d      = 1'b0;
    overrun_d   = busy
                ? (take_action_ocimem_a
                  | take_action_ocimem_b
                  | take_no_action_ocimem_a)
                : multi;
    if (acc_a) begin
      jaddr_d = jdo[10 +: ADDR_W];
    end
    if (acc_b || acc_na) begin
      pending_d = 1'b1;
      op_wr_d   = acc_b;
      wdata_d   = jdo[34:3];
    end
    if (grant_jtag) begin
      pending_d   = 1'b0;
      last_jtag_d = 1'b1;
      if (op_wr_q) begin
        jaddr_d = jaddr_q + ADDR_W'(1);
        done_d  = 1'b1;
      end
    end
    if (grant_cpu) begin
      last_jtag_d = 1'b0;
    end
    if (state_q == S_JTAG_RDATA) begin
      mondreg_d = ram_rdata;
      jaddr_d   = jaddr_q + ADDR_W'(1);
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= 1'b0;
      op_wr_q     <= 1'b0;
      wdata_q     <= '0;
      jaddr_q     <= '0;
      mondreg_q   <= '0;
      last_jtag_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      op_wr_q     <= op_wr_d;
      wdata_q     <= wdata_d;
      jaddr_q     <= jaddr_d;
      mondreg_q   <= mondreg_d;
      last_jtag_q <= last_jtag_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign MonDReg      = mondreg_q;
  assign jtag_done    = done_q;
  assign jtag_busy    = busy;
  assign jtag_overrun = overrun_q;

endmodule
